// File: rtl/mips_div_pkg.sv
// Shared constants, state encoding and sign helpers for the multi-cycle MIPS divider.
package mips_div_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned ITER  = 32;
  localparam int unsigned CNT_W = 6;

  localparam logic [WIDTH-1:0] DIVZERO_Q = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Two's complement negate when en is set; 32'h80000000 maps to itself.
  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic en);
    cond_neg = en ? WIDTH'(~x + WIDTH'(1)) : x;
  endfunction

endpackage

// File: rtl/mips_div_step.sv
// One restoring division stage: shift in the next dividend bit, compare, conditionally subtract.
module mips_div_step
  import mips_div_pkg::*;
(
  input  logic [WIDTH-1:0] rem,
  input  logic             nbit,
  input  logic [WIDTH-1:0] dvs,
  output logic [WIDTH-1:0] rem_next_c,
  output logic             qbit_c
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // 33-bit compare so divisors up to 32'h80000000 work without overflow.
  always_comb begin
    shifted    = {rem, nbit};
    diff       = shifted - {1'b0, dvs};
    qbit_c     = ~diff[WIDTH];
    rem_next_c = qbit_c ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/mips_div.sv
// 32-bit restoring divider: reset release arms one division, result after 34 edges, sticky divdone.
module mips_div
  import mips_div_pkg::*;
(
  input  logic             clk,
  input  logic             divrst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             signdiv,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             divdone
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] dvd;   // remaining dividend bits out of the MSB, quotient bits in at the LSB
  logic [WIDTH-1:0] dvs;
  logic [WIDTH-1:0] rem;
  logic             qneg;
  logic             rneg;
  logic             divzero;

  logic [WIDTH-1:0] rem_next_c;
  logic             qbit_c;

  mips_div_step u_step (
    .rem        (rem),
    .nbit       (dvd[WIDTH-1]),
    .dvs        (dvs),
    .rem_next_c (rem_next_c),
    .qbit_c     (qbit_c)
  );

  always_ff @(posedge clk or negedge divrst) begin
    if (!divrst) begin
      state   <= LOAD;
      cnt     <= '0;
      dvd     <= '0;
      dvs     <= '0;
      rem     <= '0;
      qneg    <= 1'b0;
      rneg    <= 1'b0;
      divzero <= 1'b0;
      q       <= '0;
      r       <= '0;
      divdone <= 1'b0;
    end else begin
      case (state)
        LOAD: begin
          dvd     <= cond_neg(a, signdiv & a[WIDTH-1]);
          dvs     <= cond_neg(b, signdiv & b[WIDTH-1]);
          rem     <= '0;
          qneg    <= signdiv & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg    <= signdiv & a[WIDTH-1];
          divzero <= (b == '0);
          cnt     <= CNT_W'(ITER);
          state   <= RUN;
        end
        RUN: begin
          rem <= rem_next_c;
          dvd <= {dvd[WIDTH-2:0], qbit_c};
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
            state <= DONE;
          end
        end
        DONE: begin
          // Results land once on entry and then hold until the next reset.
          if (!divdone) begin
            q       <= divzero ? DIVZERO_Q : cond_neg(dvd, qneg);
            r       <= cond_neg(rem, rneg);
            divdone <= 1'b1;
          end
        end
        default: begin
          state <= LOAD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mips_div.sv
// Self-checking bench for mips_div: vector table plus reset-in-run / reset-in-done sequences.
module tb_mips_div;

  logic        clk;
  logic        divrst;
  logic [31:0] a;
  logic [31:0] b;
  logic        signdiv;
  logic [31:0] q;
  logic [31:0] r;
  logic        divdone;

  int checks;
  int errors;

  mips_div dut (
    .clk     (clk),
    .divrst  (divrst),
    .a       (a),
    .b       (b),
    .signdiv (signdiv),
    .q       (q),
    .r       (r),
    .divdone (divdone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] eq;
    logic [31:0] er;
    string       name;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Hold reset, present operands, release at a falling edge.
  task automatic start(input logic [31:0] va, input logic [31:0] vb, input logic vs);
    divrst = 1'b0;
    a = va;
    b = vb;
    signdiv = vs;
    @(negedge clk);
    divrst = 1'b1;
  endtask

  // Count 34 edges after release; outputs must stay zero until edge 34, then hold.
  task automatic expect_result(input logic [31:0] eq, input logic [31:0] er,
                               input string name, input bit scramble);
    int early;
    early = 0;
    for (int e = 1; e <= 34; e++) begin
      @(posedge clk);
      #1;
      if (e < 34 && (divdone !== 1'b0 || q !== 32'd0 || r !== 32'd0)) early++;
      if (scramble && e == 1) begin
        a = $urandom;
        b = $urandom;
        signdiv = ~signdiv;
      end
    end
    chk({name, " early"}, 32'(early), 32'd0);
    chk({name, " divdone"}, {31'd0, divdone}, 32'd1);
    chk({name, " q"}, q, eq);
    chk({name, " r"}, r, er);
    repeat (3) @(posedge clk);
    #1;
    chk({name, " hold"}, {q ^ eq, r ^ er} == 64'd0 && divdone === 1'b1 ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    checks = 0;
    errors = 0;

    vecs[0]  = '{32'd100,      32'd7,        1'b0, 32'd14,       32'd2,        "udiv 100/7"};
    vecs[1]  = '{32'hFFFFFFF9, 32'd2,        1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF, "sdiv -7/2"};
    vecs[2]  = '{32'hFFFFFFFF, 32'd2,        1'b0, 32'h7FFFFFFF, 32'd1,        "udiv ffffffff/2"};
    vecs[3]  = '{32'hFFFFFFFF, 32'd2,        1'b1, 32'd0,        32'hFFFFFFFF, "sdiv -1/2"};
    vecs[4]  = '{32'd1234,     32'd0,        1'b0, 32'hFFFFFFFF, 32'd1234,     "udiv by zero"};
    vecs[5]  = '{32'd1234,     32'd0,        1'b1, 32'hFFFFFFFF, 32'd1234,     "sdiv by zero"};
    vecs[6]  = '{32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 32'd0,        "sdiv overflow"};
    vecs[7]  = '{32'd7,        32'hFFFFFFFE, 1'b1, 32'hFFFFFFFD, 32'd1,        "sdiv 7/-2"};
    vecs[8]  = '{32'hFFFFFFF9, 32'hFFFFFFFE, 1'b1, 32'd3,        32'hFFFFFFFF, "sdiv -7/-2"};
    vecs[9]  = '{32'h80000000, 32'd2,        1'b0, 32'h40000000, 32'd0,        "udiv msb/2"};
    vecs[10] = '{32'h80000000, 32'd2,        1'b1, 32'hC0000000, 32'd0,        "sdiv min/2"};
    vecs[11] = '{32'hFFFFFFF6, 32'd0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFF6, "sdiv -10/0"};
    vecs[12] = '{32'd5,        32'd10,       1'b0, 32'd0,        32'd5,        "udiv 5/10"};

    // Reset state.
    divrst = 1'b0;
    a = '0;
    b = '0;
    signdiv = 1'b0;
    #2;
    chk("reset q", q, 32'd0);
    chk("reset r", r, 32'd0);
    chk("reset divdone", {31'd0, divdone}, 32'd0);

    foreach (vecs[i]) begin
      // Every start after the first also pulls reset while in DONE.
      divrst = 1'b0;
      #1;
      if (i > 0) chk({vecs[i].name, " clear"}, {q[15:0] | r[15:0] | q[31:16] | r[31:16], 15'd0, divdone}, 32'd0);
      start(vecs[i].a, vecs[i].b, vecs[i].s);
      expect_result(vecs[i].eq, vecs[i].er, vecs[i].name, 1'b0);
    end

    // Operands changing after LOAD must not disturb the division.
    start(32'd1000, 32'd33, 1'b0);
    expect_result(32'd30, 32'd10, "operand scramble", 1'b1);

    // Reset at edge 10 abandons the run; new operands then take a full 34 edges.
    start(32'd100, 32'd7, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    divrst = 1'b0;
    #1;
    chk("midrun clear q", q, 32'd0);
    chk("midrun clear r", r, 32'd0);
    chk("midrun clear divdone", {31'd0, divdone}, 32'd0);
    a = 32'd50;
    b = 32'd5;
    @(negedge clk);
    divrst = 1'b1;
    expect_result(32'd10, 32'd0, "midrun restart", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
